// File: rtl/bf_uart_pkg.sv
// ============================================================================
// Module      : bf_uart_pkg
// Description : Shared definitions for the TinyBF UART link: FSM state
//               encoding, 8N1 frame constants and bit-period helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bf_uart_pkg;

    // IDLE/START/DATA/STOP carry the same meaning on the transmit side;
    // BREAK only exists on the receive side.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // 8N1 framing
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Clocks per bit period, integer truncation.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bf_sync_fifo.sv
// ============================================================================
// Module      : bf_sync_fifo
// Description : Single-clock FIFO with full/empty flags. Push and pop may
//               occur in the same cycle, including when full; the caller
//               guarantees it never pushes into a full FIFO without a pop
//               and never pops an empty one.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               push, wr_data - write strobe and data
//               pop           - read strobe (advances head)
//               rd_data       - head entry
//               full, empty   - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);

endmodule

`default_nettype wire

// File: rtl/bf_uart_rx.sv
// ============================================================================
// Module      : bf_uart_rx
// Description : 8N1 UART receiver (LSB first) with valid/ready output,
//               framing-error and overrun reporting.
//               Build option BF_UART_RX_FIFO_EN: when defined the receive
//               buffer is a FIFO_DEPTH-entry FIFO, otherwise a single
//               holding register.
// Ports       : clk_i, rst_i  - clock, asynchronous active-high reset
//               uart_rx_i     - serial line (idle high, asynchronous)
//               rx_data_o     - head-of-buffer byte
//               rx_valid_o    - byte available
//               rx_ready_i    - consumer accepts (pop on valid & ready)
//               frame_err_o   - 1-cycle pulse: stop bit sampled low
//               overrun_o     - 1-cycle pulse: good byte dropped, buffer full
//               busy_o        - receiver FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_uart_rx
    import bf_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 38400,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer; resets to the idle (high) line level so that a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic sync_meta;
    logic rxs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= uart_rx_i;
            rxs       <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    uart_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             stop_good;
    logic             stop_bad;
    logic             tick;

    logic             buf_full;
    logic             pop;
    logic             push;
    logic             overrun_now;

    // The counter is loaded with N and the sample is taken on the cycle it
    // reads 1, so the sample lands exactly N cycles after the load.
    assign tick = (cnt == CNT_ONE);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        stop_good    = 1'b0;
        stop_bad     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_next   = CNT_HALF;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_next = ST_IDLE;   // glitch, not a start bit
                    end else begin
                        cnt_next     = CNT_BIT;
                        bit_idx_next = '0;
                        state_next   = ST_DATA;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_next = {rxs, shift_reg[7:1]};   // LSB arrives first
                    cnt_next   = CNT_BIT;
                    if (bit_idx == BIT_LAST) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rxs) begin
                        stop_good  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_BREAK: begin
                // A line held low must return high before a new frame counts.
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_idx     <= bit_idx_next;
            shift_reg   <= shift_next;
            frame_err_o <= stop_bad;
            overrun_o   <= overrun_now;
        end
    end

    assign busy_o = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Buffer control. A pop in the same cycle frees the slot for a push
    // even when the buffer is full, so that case is not an overrun.
    // ------------------------------------------------------------------
    assign pop         = rx_valid_o & rx_ready_i;
    assign push        = stop_good & (~buf_full | pop);
    assign overrun_now = stop_good & buf_full & ~pop;

`ifdef BF_UART_RX_FIFO_EN
    logic fifo_empty;

    bf_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .wr_data (shift_reg),
        .pop     (pop),
        .rd_data (rx_data_o),
        .full    (buf_full),
        .empty   (fifo_empty)
    );

    assign rx_valid_o = ~fifo_empty;
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (push) begin
                hold_data  <= shift_reg;
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign buf_full   = hold_valid;
    assign rx_data_o  = hold_data;
    assign rx_valid_o = hold_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bf_uart_rx.sv
// ============================================================================
// Module      : tb_bf_uart_rx
// Description : Self-checking bench for bf_uart_rx. Stimulus tasks push the
//               expected bytes / error pulse cycles into queues; a monitor
//               on the falling clock edge pops and compares them.
//               Works with and without BF_UART_RX_FIFO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bf_uart_rx;

    localparam int C = 16;          // clocks per bit (160000 / 10000)
    localparam int H = C / 2;
`ifdef BF_UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    localparam int K_TIMED = 0;     // byte expected, valid must rise at ts+1
    localparam int K_DATA  = 1;     // byte expected, no timing check
    localparam int K_OVR   = 2;     // overrun pulse expected at ts+1
    localparam int K_FE    = 3;     // frame error pulse expected at ts+1
    localparam int K_NONE  = 4;     // nothing expected

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       uart_rx  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t data_q[$];
    int   fe_q[$];
    int   ov_q[$];

    bf_uart_rx #(
        .CLK_FREQ   (160000),
        .BAUD_RATE  (10000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uart_rx_i   (uart_rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rx_ready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: actual=0x%0h expected=none (cycle %0d)", name, act, cyc);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                if (data_q.size() == 0) begin
                    unexpected("rx_byte", {24'd0, rx_data});
                end else begin
                    exp_t e;
                    e = data_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    if (e.at >= 0) check("valid_cycle", cyc, e.at);
                end
            end
            if (frame_err) begin
                if (fe_q.size() == 0) unexpected("frame_err_pulse", cyc);
                else                  check("frame_err_cycle", cyc, fe_q.pop_front());
            end
            if (overrun) begin
                if (ov_q.size() == 0) unexpected("overrun_pulse", cyc);
                else                  check("overrun_cycle", cyc, ov_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit ready_at_stop,
                        input int kind);
        int t0;
        int ts;
        step();
        uart_rx = 1'b0;
        t0 = cyc;
        ts = t0 + 2 + H + 9 * C;
        case (kind)
            K_TIMED: data_q.push_back('{data: b, at: ts + 1});
            K_DATA:  data_q.push_back('{data: b, at: -1});
            K_OVR:   ov_q.push_back(ts + 1);
            K_FE:    fe_q.push_back(ts + 1);
            default: ;
        endcase
        repeat (C) step();
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (C) step();
        end
        uart_rx = stop;
        repeat (2 + H) step();          // now in the stop-sample cycle ts
        if (ready_at_stop) rx_ready = 1'b1;
        repeat (C - 2 - H) step();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int t0;
        repeat (3) step();
        check("reset_valid",     rx_valid,  0);
        check("reset_data",      rx_data,   0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun",   overrun,   0);
        check("reset_busy",      busy,      0);
        rst = 1'b0;
        repeat (5) step();

        // Plain byte, consumer always ready
        rx_ready = 1'b1;
        send(8'hA5, 1'b1, 1'b0, K_TIMED);
        repeat (20) step();

        // Short low glitch on an idle line
        step();
        uart_rx = 1'b0;
        t0 = cyc;
        repeat (5) step();
        uart_rx = 1'b1;
        repeat (2 + H - 5) step();
        check("glitch_busy_at_sample", busy, 1);
        step();
        check("glitch_busy_released", busy, 0);
        repeat (3 * C) step();

        // Framing error, held-low line, then recovery
        send(8'h3C, 1'b0, 1'b0, K_FE);
        repeat (3 * 10 * C) step();
        check("break_busy", busy, 1);
        uart_rx = 1'b1;
        repeat (10) step();
        check("break_exit_busy", busy, 0);
        send(8'h11, 1'b1, 1'b0, K_TIMED);
        repeat (20) step();

        // Fill the buffer with the consumer stalled
        rx_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            send(8'(b), 1'b1, 1'b0, (b <= CAP) ? K_DATA : K_OVR);
        end
        repeat (4) step();
        check("full_valid", rx_valid, 1);
        check("full_head",  rx_data,  8'h01);

        // Consumer wakes exactly on the stop sample of the next byte
        send(8'h7E, 1'b1, 1'b1, K_DATA);
        repeat (20) step();
        check("drain_empty", data_q.size(), 0);

        // Reset in the middle of a frame clears everything
        rx_ready = 1'b0;
        send(8'h5A, 1'b1, 1'b0, K_NONE);
        repeat (4) step();
        check("held_valid", rx_valid, 1);
        check("held_data",  rx_data,  8'h5A);
        step();
        uart_rx = 1'b0;
        repeat (C) step();
        for (int k = 0; k < 4; k++) begin
            uart_rx = 1'b1;
            repeat (C) step();
        end
        repeat (H) step();
        check("busy_mid_frame", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_reset_valid",     rx_valid,  0);
        check("mid_reset_data",      rx_data,   0);
        check("mid_reset_busy",      busy,      0);
        check("mid_reset_frame_err", frame_err, 0);
        check("mid_reset_overrun",   overrun,   0);
        repeat (3) step();
        rst = 1'b0;
        repeat (3 * C) step();
        rx_ready = 1'b1;
        send(8'h42, 1'b1, 1'b0, K_TIMED);
        repeat (20) step();

        check("final_data_q", data_q.size(), 0);
        check("final_fe_q",   fe_q.size(),   0);
        check("final_ov_q",   ov_q.size(),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/bf_uart_rx.md
# bf_uart_rx

Serial receiver for the TinyBF UART link: samples the asynchronous `uart_rx_i` line (8N1, LSB first) and delivers each received byte to the CPU's `,` (input) command path over a valid/ready handshake. It is the receiving end of the same protocol the core's transmitter drives on `uart_tx_o`. It sits inside `bf_top` between the board pin `ui[0]` and the execution unit. It also reports framing and overrun errors.

## Interface
- `CLK_FREQ`, default 50000000: system clock in Hz.
- `BAUD_RATE`, default 38400: line rate in baud.
- `CLKS_PER_BIT`, default CLK_FREQ/BAUD_RATE (integer truncation, 1302): clocks per bit; must be ≥ 4.
- `FIFO_DEPTH`, default 4: receive buffer depth (power of two); used only with `BF_UART_RX_FIFO_EN`.

Ports:
- `clk_i`, in, 1: system clock; all logic on its rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `uart_rx_i`, in, 1: serial line, idle high, asynchronous to `clk_i`.
- `rx_data_o`, out, 8: head-of-buffer byte, valid while `rx_valid_o`.
- `rx_valid_o`, out, 1: byte available.
- `rx_ready_i`, in, 1: consumer accepts; a pop occurs on a cycle where both valid and ready are high.
- `frame_err_o`, out, 1: one-cycle pulse when a stop bit samples low.
- `overrun_o`, out, 1: one-cycle pulse when a good byte is dropped because the buffer is full.
- `busy_o`, out, 1: high whenever the FSM is not IDLE.

## Operation
- The input passes a 2-flop synchronizer with reset value 1. The FSM sees only the synchronized signal `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when `rxs` = 0, load bit counter with H = CLKS_PER_BIT/2 and go to START.
- START: when the counter expires, re-sample `rxs`. If 1, the event was a glitch: return to IDLE with no output. If 0, load CLKS_PER_BIT, clear the bit index and go to DATA.
- DATA: at each counter expiry, shift in `rxs` at bit index 0..7, LSB first. After bit 7, load CLKS_PER_BIT and go to STOP.
- STOP: at counter expiry, sample `rxs`.
  - If 1 and the buffer has space: push the byte and go to IDLE.
  - If 1 and the buffer is full: pulse `overrun_o`, discard the byte and go to IDLE.
  - If 0: pulse `frame_err_o`, discard the byte and go to BREAK.
- BREAK: wait for `rxs` = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- A push and a pop in the same cycle on a full buffer is legal. The pop frees the slot, the push is accepted, and no overrun is reported.
- `rx_data_o` and `rx_valid_o` are registered outputs driven from buffer state. `rx_data_o` is stable while `rx_valid_o` is high and not yet popped.
- Reset values: `rx_data_o` = 0x00, `rx_valid_o` = 0, `frame_err_o` = 0, `overrun_o` = 0, `busy_o` = 0. FSM state is IDLE, the buffer is empty and the synchronizer holds 1.
- Reset asserted mid-frame aborts the frame immediately and clears any buffered bytes.

## Timing
- Let a falling edge on `uart_rx_i` be sampled at cycle t0. IDLE sees it at t0+2.
- Start-bit mid-sample occurs at t0+2+H.
- Data bit k is sampled at t0+2+H+(k+1)·CLKS_PER_BIT.
- The stop bit is sampled at ts = t0+2+H+9·CLKS_PER_BIT.
- `rx_valid_o` rises at ts+1 when the buffer was empty. `frame_err_o` and `overrun_o` pulse at ts+1.
- After a pop, the next byte (if any) appears the following cycle.
- With the defaults, ts = t0+12371.
- A back-to-back start bit directly after the stop bit is accepted. IDLE is re-entered at ts+1, half a bit before the stop bit ends.

## Configuration
- `BF_UART_RX_FIFO_EN` defined: the buffer is a FIFO of FIFO_DEPTH entries.
- `BF_UART_RX_FIFO_EN` undefined: the buffer is a single holding register, so FIFO_DEPTH is ignored and a second byte arriving before a pop raises overrun.
- Handshake, timing and error behaviour are otherwise identical.

## Structure
- Package `bf_uart_pkg` holds:
  - the FSM state enum (shared with the transmitter's states where identical);
  - the 8N1 frame constants (8 data bits, 1 stop bit);
  - a function computing CLKS_PER_BIT from CLK_FREQ/BAUD_RATE.
- Sub-module `bf_sync_fifo` (width 8, depth FIFO_DEPTH, with full/empty flags and same-cycle push/pop) is instantiated only under `BF_UART_RX_FIFO_EN`.

## Test plan
- Send 0xA5 with `rx_ready_i` = 1 → `rx_valid_o` pulses one cycle at ts+1 with `rx_data_o` = 0xA5 and no error pulses.
- Apply a 300-cycle low glitch on an idle line → no output and no errors; `busy_o` returns to 0 at t0+2+H+1.
- Send 0x3C with the stop bit driven low → `frame_err_o` pulse and no valid. Hold the line low for 3 frames → the FSM stays in BREAK with no further pulses. Release the line and send 0x11 → 0x11 is received.
- With `rx_ready_i` = 0, send bytes 0x01 through 0x05:
  - FIFO build: bytes 0x01..0x04 are buffered and `overrun_o` pulses on 0x05. Popping afterwards yields 0x01, 0x02, 0x03, 0x04 in order.
  - Register build: `overrun_o` pulses on 0x02 and the pop yields 0x01.
- With the buffer full, raise `rx_ready_i` exactly at the stop-sample cycle of a new byte 0x7E → no overrun, and 0x7E is later delivered.
- Assert `rst_i` at data bit 4 of 0xFF → all outputs return to reset values immediately. The next frame, 0x42, is received correctly.
